// File: rtl/servisia_sram_arb_pkg.sv
// Shared constants and FSM encoding for the servisia SRAM arbiter.
// Optional statistics counters are enabled with SERVISIA_SRAM_ARB_STATS_EN.
package servisia_sram_arb_pkg;

   localparam int DW         = 8;
   localparam int AW_DEFAULT = 14;

   typedef enum logic [1:0] {
      HALTED  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      DRAIN   = 2'd3
   } arb_state_t;

   // RELEASE and DRAIN are single-cycle hand-over states regardless of halt.
   function automatic arb_state_t arb_next(input arb_state_t cur, input logic halt);
      case (cur)
         HALTED:  return halt ? HALTED : RELEASE;
         RELEASE: return RUN;
         RUN:     return halt ? DRAIN : RUN;
         DRAIN:   return HALTED;
         default: return HALTED;
      endcase
   endfunction

endpackage

// File: rtl/servisia_sram_arb_if.sv
// Core, host and SRAM-side signals of the servisia SRAM arbiter.
// Counter outputs exist only when SERVISIA_SRAM_ARB_STATS_EN is defined.
interface servisia_sram_arb_if #(parameter int AW = servisia_sram_arb_pkg::AW_DEFAULT);
   import servisia_sram_arb_pkg::*;

   logic [AW-1:0] core_waddr_i;
   logic [DW-1:0] core_wdata_i;
   logic          core_wen_i;
   logic [AW-1:0] core_raddr_i;
   logic          core_ren_i;
   logic [DW-1:0] core_rdata_o;
   logic          core_rst_o;
   logic          host_req_i;
   logic          host_we_i;
   logic [AW-1:0] host_addr_i;
   logic [DW-1:0] host_wdata_i;
   logic          host_gnt_o;
   logic          host_rvalid_o;
   logic [DW-1:0] host_rdata_o;
   logic          host_halt_i;
   logic          host_halted_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_wdata_o;
   logic          sram_write_o;
   logic          sram_read_o;
   logic [DW-1:0] sram_rdata_i;
`ifdef SERVISIA_SRAM_ARB_STATS_EN
   logic [31:0]   host_wait_cnt_o;
   logic [31:0]   host_xfer_cnt_o;
`endif

   // Arbiter side.
   modport slave (
      input  core_waddr_i, core_wdata_i, core_wen_i, core_raddr_i, core_ren_i,
      input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_halt_i,
      input  sram_rdata_i,
      output core_rdata_o, core_rst_o, host_gnt_o, host_rvalid_o, host_rdata_o,
      output host_halted_o, sram_addr_o, sram_wdata_o, sram_write_o, sram_read_o
`ifdef SERVISIA_SRAM_ARB_STATS_EN
      , output host_wait_cnt_o, host_xfer_cnt_o
`endif
   );

   // Requester / memory environment side.
   modport master (
      output core_waddr_i, core_wdata_i, core_wen_i, core_raddr_i, core_ren_i,
      output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_halt_i,
      output sram_rdata_i,
      input  core_rdata_o, core_rst_o, host_gnt_o, host_rvalid_o, host_rdata_o,
      input  host_halted_o, sram_addr_o, sram_wdata_o, sram_write_o, sram_read_o
`ifdef SERVISIA_SRAM_ARB_STATS_EN
      , input host_wait_cnt_o, host_xfer_cnt_o
`endif
   );

endinterface

// File: rtl/servisia_sram_arb_stats.sv
// Host wait/transfer cycle counters; both wrap at 2^32.
// Instantiated only when SERVISIA_SRAM_ARB_STATS_EN is defined.
module servisia_sram_arb_stats (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        host_req_i,
   input  logic        host_gnt_i,
   output logic [31:0] host_wait_cnt_o,
   output logic [31:0] host_xfer_cnt_o
);

   // Count blocked host cycles and issued host accesses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         host_wait_cnt_o <= 32'd0;
         host_xfer_cnt_o <= 32'd0;
      end else begin
         if (host_req_i && !host_gnt_i) begin
            host_wait_cnt_o <= host_wait_cnt_o + 32'd1;
         end
         if (host_gnt_i) begin
            host_xfer_cnt_o <= host_xfer_cnt_o + 32'd1;
         end
      end
   end

endmodule

// File: rtl/servisia_sram_arb.sv
// Shares a single-port byte SRAM between the servisia core (priority) and a host port.
// Define SERVISIA_SRAM_ARB_STATS_EN to add host wait/transfer counters.
module servisia_sram_arb
   import servisia_sram_arb_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input logic                clk_i,
   input logic                rst_i,
   servisia_sram_arb_if.slave bus
);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic          core_rst;
   logic          halted;
   logic          rvalid;
   logic          core_act;
   logic          host_gnt;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          wr;
   logic          rd;

   // Request arbitration and SRAM strobe mux; the core cannot stall, so it always wins.
   always_comb begin
      state_nxt = arb_next(state, bus.host_halt_i);
      core_act  = (state == RUN) && (bus.core_wen_i || bus.core_ren_i);
      host_gnt  = bus.host_req_i && !core_act;
      addr      = '0;
      wdata     = bus.core_wdata_i;
      wr        = 1'b0;
      rd        = 1'b0;
      if (host_gnt) begin
         addr  = bus.host_addr_i;
         wdata = bus.host_wdata_i;
         wr    = bus.host_we_i;
         rd    = !bus.host_we_i;
      end else if (core_act && bus.core_wen_i) begin
         addr = bus.core_waddr_i;
         wr   = 1'b1;
      end else if (core_act) begin
         addr = bus.core_raddr_i;
         rd   = 1'b1;
      end else begin
         addr = '0;
      end
   end

   // Halt/run FSM with registered core reset, halted flag and host read-valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= HALTED;
         core_rst <= 1'b1;
         halted   <= 1'b1;
         rvalid   <= 1'b0;
      end else begin
         state    <= state_nxt;
         core_rst <= (state_nxt != RUN);
         halted   <= (state_nxt == HALTED);
         rvalid   <= host_gnt && !bus.host_we_i;
      end
   end

   assign bus.core_rst_o    = core_rst;
   assign bus.host_halted_o = halted;
   assign bus.host_rvalid_o = rvalid;
   assign bus.host_gnt_o    = host_gnt;
   assign bus.sram_addr_o   = addr;
   assign bus.sram_wdata_o  = wdata;
   assign bus.sram_write_o  = wr;
   assign bus.sram_read_o   = rd;
   assign bus.core_rdata_o  = bus.sram_rdata_i;
   assign bus.host_rdata_o  = bus.sram_rdata_i;

`ifdef SERVISIA_SRAM_ARB_STATS_EN
   servisia_sram_arb_stats u_stats (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .host_req_i      (bus.host_req_i),
      .host_gnt_i      (host_gnt),
      .host_wait_cnt_o (bus.host_wait_cnt_o),
      .host_xfer_cnt_o (bus.host_xfer_cnt_o)
   );
`endif

endmodule

// File: tb/tb_servisia_sram_arb.sv
// Directed bench for servisia_sram_arb with a behavioural 1-cycle-latency SRAM.
// Counter checks are compiled in with SERVISIA_SRAM_ARB_STATS_EN.
module tb_servisia_sram_arb;
   localparam int AW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   loaded = 1'b0;
   logic [7:0] mem [0:(1<<AW)-1];

   servisia_sram_arb_if #(.AW(AW)) bus ();

   servisia_sram_arb #(.AW(AW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // SRAM model, preloaded with mem[a] = a[7:0] ^ 8'hA5.
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i) ^ 8'hA5;
         loaded <= 1'b1;
      end else begin
         if (bus.sram_write_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
         if (bus.sram_read_o) bus.sram_rdata_i <= mem[bus.sram_addr_o];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.core_waddr_i = '0;
      bus.core_wdata_i = 8'h00;
      bus.core_wen_i   = 1'b0;
      bus.core_raddr_i = '0;
      bus.core_ren_i   = 1'b0;
      bus.host_req_i   = 1'b0;
      bus.host_we_i    = 1'b0;
      bus.host_addr_i  = '0;
      bus.host_wdata_i = 8'h00;
      bus.host_halt_i  = 1'b0;
      tick(); tick();
      check("rst_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("rst_halted",   32'(bus.host_halted_o), 32'd1);
      check("rst_rvalid",   32'(bus.host_rvalid_o), 32'd0);
      check("rst_gnt",      32'(bus.host_gnt_o), 32'd0);

      // Reset release with halt low; core read must be ignored until RUN.
      rst = 1'b0; bus.core_ren_i = 1'b1; bus.core_raddr_i = 14'h0020; #1;
      check("c1_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("c1_read",     32'(bus.sram_read_o), 32'd0);
      tick();
      check("c2_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("c2_halted",   32'(bus.host_halted_o), 32'd0);
      check("c2_read",     32'(bus.sram_read_o), 32'd0);
      check("c2_write",    32'(bus.sram_write_o), 32'd0);
      tick();
      check("c3_core_rst", 32'(bus.core_rst_o), 32'd0);
      check("c3_read",     32'(bus.sram_read_o), 32'd1);

      // Halt: RUN -> DRAIN -> HALTED.
      bus.core_ren_i = 1'b0; bus.host_halt_i = 1'b1;
      tick();
      check("drain_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("drain_halted",   32'(bus.host_halted_o), 32'd0);
      tick();
      check("halted", 32'(bus.host_halted_o), 32'd1);

      // Halted: host write 0x5A @0x0123, read it back, then read 0x0010.
      bus.host_req_i = 1'b1; bus.host_we_i = 1'b1;
      bus.host_addr_i = 14'h0123; bus.host_wdata_i = 8'h5A; #1;
      check("hw_gnt",   32'(bus.host_gnt_o), 32'd1);
      check("hw_write", 32'(bus.sram_write_o), 32'd1);
      check("hw_read",  32'(bus.sram_read_o), 32'd0);
      check("hw_addr",  32'(bus.sram_addr_o), 32'h0123);
      check("hw_wdata", 32'(bus.sram_wdata_o), 32'h5A);
      tick();
      bus.host_we_i = 1'b0; #1;
      check("hr_gnt",    32'(bus.host_gnt_o), 32'd1);
      check("hr_read",   32'(bus.sram_read_o), 32'd1);
      check("hr_write",  32'(bus.sram_write_o), 32'd0);
      check("hw_rvalid", 32'(bus.host_rvalid_o), 32'd0);
      tick();
      bus.host_addr_i = 14'h0010; #1;
      check("hr1_rvalid", 32'(bus.host_rvalid_o), 32'd1);
      check("hr1_rdata",  32'(bus.host_rdata_o), 32'h5A);
      check("hr2_gnt",    32'(bus.host_gnt_o), 32'd1);
      tick();
      bus.host_req_i = 1'b0; #1;
      check("hr2_rvalid", 32'(bus.host_rvalid_o), 32'd1);
      check("hr2_rdata",  32'(bus.host_rdata_o), 32'hB5);
      tick();
      check("hr_idle_rvalid", 32'(bus.host_rvalid_o), 32'd0);

      // Release: HALTED -> RELEASE -> RUN.
      bus.host_halt_i = 1'b0;
      tick();
      check("rel_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("rel_halted",   32'(bus.host_halted_o), 32'd0);
      tick();
      check("run_core_rst", 32'(bus.core_rst_o), 32'd0);

      // Core reads every cycle; host read 0x0010 waits for an idle core cycle.
      bus.core_ren_i = 1'b1; bus.core_raddr_i = 14'h0020;
      bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 14'h0010; #1;
      check("starve_gnt0", 32'(bus.host_gnt_o), 32'd0);
      check("starve_read", 32'(bus.sram_read_o), 32'd1);
      check("starve_addr", 32'(bus.sram_addr_o), 32'h0020);
      tick();
      check("starve_gnt1",   32'(bus.host_gnt_o), 32'd0);
      check("core_rdata",    32'(bus.core_rdata_o), 32'h85);
      check("starve_rvalid", 32'(bus.host_rvalid_o), 32'd0);
      tick();
      bus.core_ren_i = 1'b0; #1;
      check("idle_gnt",  32'(bus.host_gnt_o), 32'd1);
      check("idle_addr", 32'(bus.sram_addr_o), 32'h0010);
      check("idle_read", 32'(bus.sram_read_o), 32'd1);
      tick();
      bus.host_req_i = 1'b0; #1;
      check("idle_rvalid", 32'(bus.host_rvalid_o), 32'd1);
      check("idle_rdata",  32'(bus.host_rdata_o), 32'hB5);

      // Core write and read in the same cycle: write wins.
      bus.core_wen_i = 1'b1; bus.core_waddr_i = 14'h0004; bus.core_wdata_i = 8'h77;
      bus.core_ren_i = 1'b1; bus.core_raddr_i = 14'h0008; #1;
      check("wr_write", 32'(bus.sram_write_o), 32'd1);
      check("wr_read",  32'(bus.sram_read_o), 32'd0);
      check("wr_addr",  32'(bus.sram_addr_o), 32'h0004);
      check("wr_wdata", 32'(bus.sram_wdata_o), 32'h77);
      tick();

      // Core read with halt rising the same cycle: data returns in DRAIN without rvalid.
      bus.core_wen_i = 1'b0; bus.core_raddr_i = 14'h0004; bus.host_halt_i = 1'b1; #1;
      check("hd_read", 32'(bus.sram_read_o), 32'd1);
      check("hd_addr", 32'(bus.sram_addr_o), 32'h0004);
      tick();
      check("dr_core_rdata", 32'(bus.core_rdata_o), 32'h77);
      check("dr_rvalid",     32'(bus.host_rvalid_o), 32'd0);
      check("dr_core_rst",   32'(bus.core_rst_o), 32'd1);
      check("dr_read",       32'(bus.sram_read_o), 32'd0);
      tick();
      bus.host_halt_i = 1'b0; bus.core_ren_i = 1'b0; #1;
      check("dh_halted",   32'(bus.host_halted_o), 32'd1);
      check("dh_core_rst", 32'(bus.core_rst_o), 32'd1);
      tick();
      check("dl_core_rst", 32'(bus.core_rst_o), 32'd1);
      tick();
      check("dl_run_core_rst", 32'(bus.core_rst_o), 32'd0);
      check("dl_run_halted",   32'(bus.host_halted_o), 32'd0);

      // Reset during a granted host read drops the pending rvalid.
      bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 14'h0123; #1;
      check("mr_gnt", 32'(bus.host_gnt_o), 32'd1);
      rst = 1'b1;
      tick();
      bus.host_req_i = 1'b0; #1;
      check("mr_rvalid",   32'(bus.host_rvalid_o), 32'd0);
      check("mr_core_rst", 32'(bus.core_rst_o), 32'd1);
      check("mr_halted",   32'(bus.host_halted_o), 32'd1);

      rst = 1'b0;
      tick(); tick();
      check("mr_run_core_rst", 32'(bus.core_rst_o), 32'd0);
`ifdef SERVISIA_SRAM_ARB_STATS_EN
      check("st_wait0", bus.host_wait_cnt_o, 32'd0);
      check("st_xfer0", bus.host_xfer_cnt_o, 32'd0);
      bus.core_ren_i = 1'b1; bus.core_raddr_i = 14'h0020;
      bus.host_req_i = 1'b1; bus.host_addr_i = 14'h0010;
      tick(); tick(); tick();
      bus.core_ren_i = 1'b0;
      tick(); tick();
      bus.host_req_i = 1'b0; #1;
      check("st_wait3", bus.host_wait_cnt_o, 32'd3);
      check("st_xfer2", bus.host_xfer_cnt_o, 32'd2);
      rst = 1'b1;
      tick();
      check("st_wait_rst", bus.host_wait_cnt_o, 32'd0);
      check("st_xfer_rst", bus.host_xfer_cnt_o, 32'd0);
      rst = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
